// File: rtl/phys_free_list_if.sv
// Free-list bus between the rename/dispatch and commit logic and phys_free_list.
// Groups the per-slot allocate requests/grants, the per-slot commit releases
// and the status outputs. With PHYS_FL_CKPT_EN defined it also carries the
// checkpoint save/restore controls and the saved head pointer.
interface phys_free_list_if #(
   parameter int TAG_W = 6,
   parameter int CNT_W = 6
);
   logic             DS_Inst1_Req;
   logic             DS_Inst2_Req;
   logic             DS_Inst3_Req;
   logic             DS_Inst4_Req;
   logic [TAG_W-1:0] DS_Inst1_Phy;
   logic [TAG_W-1:0] DS_Inst2_Phy;
   logic [TAG_W-1:0] DS_Inst3_Phy;
   logic [TAG_W-1:0] DS_Inst4_Phy;
   logic             alloc_ok;
   logic             CM_Inst1_Rel;
   logic             CM_Inst2_Rel;
   logic             CM_Inst3_Rel;
   logic             CM_Inst4_Rel;
   logic [TAG_W-1:0] CM_Inst1_Phy;
   logic [TAG_W-1:0] CM_Inst2_Phy;
   logic [TAG_W-1:0] CM_Inst3_Phy;
   logic [TAG_W-1:0] CM_Inst4_Phy;
   logic [CNT_W-1:0] free_count;
   logic             fl_overflow;
`ifdef PHYS_FL_CKPT_EN
   logic             ckpt_save;
   logic             ckpt_restore;
   logic [CNT_W-1:0] ckpt_head;

   modport master (
      output DS_Inst1_Req, DS_Inst2_Req, DS_Inst3_Req, DS_Inst4_Req,
      output CM_Inst1_Rel, CM_Inst2_Rel, CM_Inst3_Rel, CM_Inst4_Rel,
      output CM_Inst1_Phy, CM_Inst2_Phy, CM_Inst3_Phy, CM_Inst4_Phy,
      output ckpt_save, ckpt_restore,
      input  DS_Inst1_Phy, DS_Inst2_Phy, DS_Inst3_Phy, DS_Inst4_Phy,
      input  alloc_ok, free_count, fl_overflow, ckpt_head
   );

   modport slave (
      input  DS_Inst1_Req, DS_Inst2_Req, DS_Inst3_Req, DS_Inst4_Req,
      input  CM_Inst1_Rel, CM_Inst2_Rel, CM_Inst3_Rel, CM_Inst4_Rel,
      input  CM_Inst1_Phy, CM_Inst2_Phy, CM_Inst3_Phy, CM_Inst4_Phy,
      input  ckpt_save, ckpt_restore,
      output DS_Inst1_Phy, DS_Inst2_Phy, DS_Inst3_Phy, DS_Inst4_Phy,
      output alloc_ok, free_count, fl_overflow, ckpt_head
   );
`else
   modport master (
      output DS_Inst1_Req, DS_Inst2_Req, DS_Inst3_Req, DS_Inst4_Req,
      output CM_Inst1_Rel, CM_Inst2_Rel, CM_Inst3_Rel, CM_Inst4_Rel,
      output CM_Inst1_Phy, CM_Inst2_Phy, CM_Inst3_Phy, CM_Inst4_Phy,
      input  DS_Inst1_Phy, DS_Inst2_Phy, DS_Inst3_Phy, DS_Inst4_Phy,
      input  alloc_ok, free_count, fl_overflow
   );

   modport slave (
      input  DS_Inst1_Req, DS_Inst2_Req, DS_Inst3_Req, DS_Inst4_Req,
      input  CM_Inst1_Rel, CM_Inst2_Rel, CM_Inst3_Rel, CM_Inst4_Rel,
      input  CM_Inst1_Phy, CM_Inst2_Phy, CM_Inst3_Phy, CM_Inst4_Phy,
      output DS_Inst1_Phy, DS_Inst2_Phy, DS_Inst3_Phy, DS_Inst4_Phy,
      output alloc_ok, free_count, fl_overflow
   );
`endif
endinterface

// File: rtl/phys_free_list.sv
// PhysFreeList: circular free list of physical register tags for a 4-wide
// rename stage. Hands out up to four tags per cycle (all-or-nothing) and takes
// back up to four tags released at commit. Pointers carry one extra wrap bit so
// that a full list (32 free) and an empty list (0 free) are distinguishable.
// Optional feature macro: PHYS_FL_CKPT_EN adds a single head-pointer checkpoint
// (save / restore) used to undo allocations after a misprediction.
module phys_free_list #(
   parameter int NUM_PHY  = 64,
   parameter int NUM_ARCH = 32
) (
   input logic              clk,
   input logic              rst,
   phys_free_list_if.slave  fl
);
   localparam int TAG_W = $clog2(NUM_PHY);
   localparam int DEPTH = NUM_PHY - NUM_ARCH;
   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [TAG_W-1:0] list_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [PTR_W-1:0] freeCount_q, freeCount_d;
   logic             overflow_q, overflow_d;
   logic [PTR_W-1:0] ckptHead_q, ckptHead_d;

   logic [3:0]       req;
   logic [3:0]       rel;
   logic [TAG_W-1:0] relTag [4];
   logic [TAG_W-1:0] phy [4];
   logic [2:0]       nReq, nRel, reqOff, relOff, granted;
   logic             allocOk, saveReq, restoreReq, dropRelease;
   logic [PTR_W-1:0] occupancy;
   logic [PTR_W:0]   relTotal;
   logic             wrEn [4];
   logic [IDX_W-1:0] wrIdx [4];

   assign req = {fl.DS_Inst4_Req, fl.DS_Inst3_Req, fl.DS_Inst2_Req, fl.DS_Inst1_Req};
   assign rel = {fl.CM_Inst4_Rel, fl.CM_Inst3_Rel, fl.CM_Inst2_Rel, fl.CM_Inst1_Rel};
   assign relTag[0] = fl.CM_Inst1_Phy;
   assign relTag[1] = fl.CM_Inst2_Phy;
   assign relTag[2] = fl.CM_Inst3_Phy;
   assign relTag[3] = fl.CM_Inst4_Phy;

`ifdef PHYS_FL_CKPT_EN
   assign saveReq      = fl.ckpt_save;
   assign restoreReq   = fl.ckpt_restore;
   assign fl.ckpt_head = ckptHead_q;
`else
   assign saveReq    = 1'b0;
   assign restoreReq = 1'b0;
`endif

   assign fl.DS_Inst1_Phy = phy[0];
   assign fl.DS_Inst2_Phy = phy[1];
   assign fl.DS_Inst3_Phy = phy[2];
   assign fl.DS_Inst4_Phy = phy[3];
   assign fl.alloc_ok     = allocOk;
   assign fl.free_count   = freeCount_q;
   assign fl.fl_overflow  = overflow_q;

   // Grant tags in slot order from the head, then work out where the releases land and the next pointers
   always_comb begin
      nReq        = 3'd0;
      nRel        = 3'd0;
      reqOff      = 3'd0;
      relOff      = 3'd0;
      allocOk     = 1'b0;
      granted     = 3'd0;
      head_d      = head_q;
      tail_d      = tail_q;
      occupancy   = '0;
      relTotal    = '0;
      dropRelease = 1'b0;
      overflow_d  = overflow_q;
      ckptHead_d  = ckptHead_q;
      freeCount_d = freeCount_q;
      for (int i = 0; i < 4; i++) begin
         phy[i]   = '0;
         wrEn[i]  = 1'b0;
         wrIdx[i] = '0;
      end

      for (int i = 0; i < 4; i++) begin
         nReq = nReq + 3'(req[i]);
         nRel = nRel + 3'(rel[i]);
      end

      allocOk = (PTR_W'(nReq) <= freeCount_q) && !restoreReq;
      granted = allocOk ? nReq : 3'd0;

      for (int i = 0; i < 4; i++) begin
         phy[i] = list_q[head_q[IDX_W-1:0] + (req[i] ? IDX_W'(reqOff) : IDX_W'(0))];
         reqOff = reqOff + 3'(req[i]);
      end

      head_d = restoreReq ? ckptHead_q : head_q + PTR_W'(granted);

      occupancy   = tail_q - head_d;
      relTotal    = {1'b0, occupancy} + (PTR_W+1)'(nRel);
      dropRelease = relTotal > (PTR_W+1)'(DEPTH);
      if (dropRelease) begin
         overflow_d = 1'b1;
      end

      for (int i = 0; i < 4; i++) begin
         wrEn[i]  = rel[i] && !dropRelease;
         wrIdx[i] = tail_q[IDX_W-1:0] + IDX_W'(relOff);
         relOff   = relOff + 3'(rel[i]);
      end

      tail_d      = dropRelease ? tail_q : tail_q + PTR_W'(nRel);
      freeCount_d = tail_d - head_d;

      if (saveReq && !restoreReq) begin
         ckptHead_d = head_d;
      end
   end

   // Tag storage: reset image holds the tags above the architectural mappings, releases write at the tail
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            list_q[i] <= TAG_W'(NUM_ARCH + i);
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (wrEn[i]) begin
               list_q[wrIdx[i]] <= relTag[i];
            end
         end
      end
   end

   // Pointer, count, sticky overflow and checkpoint registers
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q      <= '0;
         tail_q      <= PTR_W'(DEPTH);
         freeCount_q <= PTR_W'(DEPTH);
         overflow_q  <= 1'b0;
         ckptHead_q  <= '0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         freeCount_q <= freeCount_d;
         overflow_q  <= overflow_d;
         ckptHead_q  <= ckptHead_d;
      end
   end
endmodule

// File: tb/tb_phys_free_list.sv
// Testbench for phys_free_list: directed scenarios plus randomized traffic,
// all compared against a queue-based model of the free list.
module tb_phys_free_list;
   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   phys_free_list_if flIf ();

   phys_free_list dut (
      .clk (clk),
      .rst (rst),
      .fl  (flIf.slave)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: the free tags in allocation order, tags currently held by dispatch
   int freeQ [$];
   int inUse [$];
   int sinceSave [$];
   bit modelOverflow;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   function automatic logic [5:0] dutPhy(input int i);
      case (i)
         0:       return flIf.DS_Inst1_Phy;
         1:       return flIf.DS_Inst2_Phy;
         2:       return flIf.DS_Inst3_Phy;
         default: return flIf.DS_Inst4_Phy;
      endcase
   endfunction

   task automatic driveInputs(input logic [3:0] req, input logic [3:0] rel,
                              input logic [3:0][5:0] relTags, input bit save, input bit restore);
      flIf.DS_Inst1_Req = req[0];
      flIf.DS_Inst2_Req = req[1];
      flIf.DS_Inst3_Req = req[2];
      flIf.DS_Inst4_Req = req[3];
      flIf.CM_Inst1_Rel = rel[0];
      flIf.CM_Inst2_Rel = rel[1];
      flIf.CM_Inst3_Rel = rel[2];
      flIf.CM_Inst4_Rel = rel[3];
      flIf.CM_Inst1_Phy = relTags[0];
      flIf.CM_Inst2_Phy = relTags[1];
      flIf.CM_Inst3_Phy = relTags[2];
      flIf.CM_Inst4_Phy = relTags[3];
`ifdef PHYS_FL_CKPT_EN
      flIf.ckpt_save    = save;
      flIf.ckpt_restore = restore;
`else
      if (save || restore) begin
         $display("[TB] checkpoint controls ignored in this build");
      end
`endif
   endtask

   task automatic applyReset();
      driveInputs(4'b0, 4'b0, '0, 1'b0, 1'b0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      freeQ = {};
      for (int t = 32; t < 64; t++) freeQ.push_back(t);
      inUse = {};
      sinceSave = {};
      modelOverflow = 1'b0;
   endtask

   // One clock: drive at the falling edge, check combinational grants and registered status, advance the model
   task automatic applyStimulus(input logic [3:0] req, input logic [3:0] rel,
                                input logic [3:0][5:0] relTags, input bit save = 1'b0, input bit restore = 1'b0);
      int nReq;
      int nRel;
      int k;
      bit expOk;
      @(negedge clk);
      driveInputs(req, rel, relTags, save, restore);
      #1;
      nReq  = $countones(req);
      nRel  = $countones(rel);
      expOk = (nReq <= freeQ.size()) && !restore;
      checkOutput("alloc_ok", {31'b0, flIf.alloc_ok}, {31'b0, expOk});
      checkOutput("free_count", {26'b0, flIf.free_count}, freeQ.size());
      checkOutput("fl_overflow", {31'b0, flIf.fl_overflow}, {31'b0, modelOverflow});
      if (expOk) begin
         k = 0;
         for (int i = 0; i < 4; i++) begin
            if (req[i]) begin
               checkOutput($sformatf("phy%0d", i + 1), {26'b0, dutPhy(i)}, freeQ[k]);
               k++;
            end
         end
         for (int i = 0; i < nReq; i++) begin
            int t;
            t = freeQ.pop_front();
            inUse.push_back(t);
            sinceSave.push_back(t);
         end
      end
      if (restore) begin
         for (int j = sinceSave.size() - 1; j >= 0; j--) freeQ.push_front(sinceSave[j]);
         sinceSave = {};
      end else if (save) begin
         sinceSave = {};
      end
      if (freeQ.size() + nRel > 32) begin
         modelOverflow = 1'b1;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (rel[i]) freeQ.push_back(int'(relTags[i]));
         end
      end
      @(posedge clk);
   endtask

   initial begin
      logic [3:0][5:0] tags;
      logic [3:0]      rel;
      tags = '0;

      // Reset image and first full-width grant
      applyReset();
      applyStimulus(4'b0000, 4'b0000, tags);
      applyStimulus(4'b1111, 4'b0000, tags);
      #1;
      checkOutput("t1_free_after_4", {26'b0, flIf.free_count}, 28);
      applyStimulus(4'b0001, 4'b0000, tags);

      // Sparse request pattern takes consecutive tags in slot order
      applyReset();
      applyStimulus(4'b1010, 4'b0000, tags);
      #1;
      checkOutput("t2_free_after_2", {26'b0, flIf.free_count}, 30);

      // Drain to three, stall a group of four while a release arrives, then grant it
      applyReset();
      repeat (7) applyStimulus(4'b1111, 4'b0000, tags);
      applyStimulus(4'b0001, 4'b0000, tags);
      #1;
      checkOutput("t3_free_3", {26'b0, flIf.free_count}, 3);
      tags[0] = 6'd40;
      applyStimulus(4'b1111, 4'b0001, tags);
      #1;
      checkOutput("t3_free_4", {26'b0, flIf.free_count}, 4);
      applyStimulus(4'b1111, 4'b0000, tags);
      applyStimulus(4'b0001, 4'b0000, tags);

      // Release into a full list sets the sticky overflow and drops the tag
      applyReset();
      tags[3] = 6'd33;
      applyStimulus(4'b0000, 4'b1000, tags);
      #1;
      checkOutput("t4_overflow", {31'b0, flIf.fl_overflow}, 1);
      checkOutput("t4_free_32", {26'b0, flIf.free_count}, 32);
      applyStimulus(4'b1111, 4'b0000, tags);
      applyStimulus(4'b0000, 4'b0000, tags);

      // Alloc two and release the same two each cycle so the pointers wrap repeatedly
      applyReset();
      for (int n = 0; n < 40; n++) begin
         tags[0] = 6'(freeQ[0]);
         tags[1] = 6'(freeQ[1]);
         applyStimulus(4'b0011, 4'b0011, tags);
      end
      #1;
      checkOutput("t5_free_32", {26'b0, flIf.free_count}, 32);
      checkOutput("t5_no_overflow", {31'b0, flIf.fl_overflow}, 0);

`ifdef PHYS_FL_CKPT_EN
      // Save at head 4, allocate 8 more, restore: the same tags come out again
      applyReset();
      tags = '0;
      applyStimulus(4'b1111, 4'b0000, tags);
      applyStimulus(4'b0000, 4'b0000, tags, 1'b1, 1'b0);
      #1;
      checkOutput("t6_ckpt_head", {26'b0, flIf.ckpt_head}, 4);
      applyStimulus(4'b1111, 4'b0000, tags);
      applyStimulus(4'b1111, 4'b0000, tags);
      applyStimulus(4'b1111, 4'b0000, tags, 1'b0, 1'b1);
      #1;
      checkOutput("t6_free_restored", {26'b0, flIf.free_count}, 28);
      applyStimulus(4'b1111, 4'b0000, tags);
`endif

      // Randomized traffic: releases only return tags dispatch currently holds, with a reset mid-run
      applyReset();
      for (int n = 0; n < 400; n++) begin
         int relPct;
         if (n == 200) applyReset();
         relPct = (n % 200 < 80) ? 20 : 70;
         rel  = 4'b0;
         tags = '0;
         for (int i = 0; i < 4; i++) begin
            if (inUse.size() > 0 && $urandom_range(99, 0) < relPct) begin
               int idx;
               idx = $urandom_range(inUse.size() - 1, 0);
               rel[i]  = 1'b1;
               tags[i] = 6'(inUse[idx]);
               inUse.delete(idx);
            end
         end
         applyStimulus(4'($urandom_range(15, 0)), rel, tags);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
